// File: rtl/rob.sv
// Reorder buffer between rename and retire: in-order allocate, out-of-order completion,
// in-order retire that commits to the architectural RAT and frees superseded phys regs.
module rob #(
  parameter int ROB_DEPTH      = 4,
  parameter int PHYSREGS_DEPTH = 6,
  parameter int ARCHREG_BITS   = 5
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   FREEZE,
  input  logic                                   flush_IN,
  input  logic                                   fREN_pushReq_IN,
  input  logic [ARCHREG_BITS+2*PHYSREGS_DEPTH:0] fREN_pushData_IN,
  output logic                                   tREN_full_OUT,
  output logic [ROB_DEPTH-1:0]                   tREN_tailTag_OUT,
  input  logic                                   fEX_completeReq_IN,
  input  logic [ROB_DEPTH-1:0]                   fEX_completeTag_IN,
  output logic                                   tFreeL_pushReq_OUT,
  output logic [PHYSREGS_DEPTH-1:0]              tFreeL_pushData_OUT,
  output logic                                   tARAT_writeReq_OUT,
  output logic [ARCHREG_BITS-1:0]                tARAT_writeArch_OUT,
  output logic [PHYSREGS_DEPTH-1:0]              tARAT_writePhys_OUT,
  output logic [ROB_DEPTH:0]                     tROB_count_OUT
);

  localparam int ENTRIES = 1 << ROB_DEPTH;
  localparam int DATA_W  = 1 + ARCHREG_BITS + 2*PHYSREGS_DEPTH;
  localparam logic [ROB_DEPTH:0] FULL_CNT = {1'b1, {ROB_DEPTH{1'b0}}};
  localparam logic [ROB_DEPTH:0] PTR_ONE  = 1;

  logic [ROB_DEPTH:0]  r_head, r_tail;
  logic [ENTRIES-1:0]  r_valid, r_done;
  logic [DATA_W-1:0]   r_data [ENTRIES];

  logic                      r_arat_req, r_freel_req;
  logic [ARCHREG_BITS-1:0]   r_arat_arch;
  logic [PHYSREGS_DEPTH-1:0] r_arat_phys, r_freel_phys;

  logic [ROB_DEPTH:0]        w_count;
  logic                      w_full;
  logic [ROB_DEPTH-1:0]      w_head_idx, w_tail_idx;
  logic                      w_push, w_complete, w_retire, w_commit;
  logic [DATA_W-1:0]         w_head_data;
  logic                      w_is_wr;
  logic [ARCHREG_BITS-1:0]   w_arch;
  logic [PHYSREGS_DEPTH-1:0] w_new, w_old;

  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == FULL_CNT);
  assign w_head_idx = r_head[ROB_DEPTH-1:0];
  assign w_tail_idx = r_tail[ROB_DEPTH-1:0];

  assign w_push     = fREN_pushReq_IN && !w_full && !FREEZE && !flush_IN;
  assign w_complete = fEX_completeReq_IN && r_valid[fEX_completeTag_IN] && !flush_IN;
  assign w_retire   = r_valid[w_head_idx] && r_done[w_head_idx] && !FREEZE && !flush_IN;

  assign w_head_data = r_data[w_head_idx];
  assign w_is_wr     = w_head_data[DATA_W-1];
  assign w_arch      = w_head_data[2*PHYSREGS_DEPTH +: ARCHREG_BITS];
  assign w_new       = w_head_data[PHYSREGS_DEPTH +: PHYSREGS_DEPTH];
  assign w_old       = w_head_data[0 +: PHYSREGS_DEPTH];
  // arch reg 0 is hardwired, so it never gets a mapping or frees anything
  assign w_commit    = w_retire && w_is_wr && (w_arch != '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else if (flush_IN) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_retire) begin
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + PTR_ONE;
      end
      if (w_complete)
        r_done[fEX_completeTag_IN] <= 1'b1;
      // placed last so a same-tag completion loses to the new allocation
      if (w_push) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + PTR_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push)
      r_data[w_tail_idx] <= fREN_pushData_IN;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_arat_req   <= 1'b0;
      r_freel_req  <= 1'b0;
      r_arat_arch  <= '0;
      r_arat_phys  <= '0;
      r_freel_phys <= '0;
    end else begin
      r_arat_req  <= w_commit;
      r_freel_req <= w_commit;
      if (w_commit) begin
        r_arat_arch  <= w_arch;
        r_arat_phys  <= w_new;
        r_freel_phys <= w_old;
      end
    end
  end

  assign tREN_full_OUT       = w_full;
  assign tREN_tailTag_OUT    = w_tail_idx;
  assign tROB_count_OUT      = w_count;
  assign tARAT_writeReq_OUT  = r_arat_req;
  assign tARAT_writeArch_OUT = r_arat_arch;
  assign tARAT_writePhys_OUT = r_arat_phys;
  assign tFreeL_pushReq_OUT  = r_freel_req;
  assign tFreeL_pushData_OUT = r_freel_phys;

endmodule
